// File: rtl/cdb_types.sv
// Shared CDB payload type and width constants for the integer back end.
package cdb_types;

   localparam int unsigned NUM_FU_LANES = 4;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned ROB_IDX_W    = 5;
   localparam int unsigned PRF_IDX_W    = 6;
   localparam int unsigned ARF_IDX_W    = 5;
   localparam int unsigned CNT_W        = 32;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_id;
      logic [PRF_IDX_W-1:0] pd;
      logic [ARF_IDX_W-1:0] rd;
      logic [DATA_W-1:0]    data;
      logic                 regf_we;
   } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
module rr_arbiter #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      int unsigned      pos;
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      found       = 1'b0;
      idx         = '0;
      pos         = 0;
      // Walk lanes ptr, ptr+1, ... modulo N; the first hit wins.
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(ptr_i) + k) % N;
         idx = IDX_W'(pos);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
      gnt_valid_o = found;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin collector of FU results onto the single registered common data bus.
module cdb_arbiter
   import cdb_types::*;
#(
   parameter int unsigned NUM_FU = NUM_FU_LANES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [NUM_FU-1:0]     fu_valid,
   output logic [NUM_FU-1:0]     fu_ready,
   input  cdb_pkt_t [NUM_FU-1:0] fu_pkt,
   output logic                  cdb_valid,
   output cdb_pkt_t              cdb_pkt,
   output logic [CNT_W-1:0]      conflict_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_FU);

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              cdb_valid_q, cdb_valid_d;
   cdb_pkt_t          cdb_pkt_q, cdb_pkt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [NUM_FU-1:0] req;
   logic [NUM_FU-1:0] gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_valid;

   // Flush and reset mask every request so no transfer can happen that cycle.
   assign req = (rst || flush) ? '0 : fu_valid;

   rr_arbiter #(.N(NUM_FU)) u_rr (
      .req_i       (req),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   assign fu_ready = gnt;

   always_comb begin
      ptr_d       = ptr_q;
      cdb_valid_d = 1'b0;
      cdb_pkt_d   = cdb_pkt_q;
      cnt_d       = cnt_q;
      if (gnt_valid) begin
         ptr_d       = (gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
         cdb_valid_d = 1'b1;
         cdb_pkt_d   = fu_pkt[gnt_idx];
      end
      // Contention counter saturates instead of wrapping.
      if (($countones(fu_valid) > 1) && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_pkt_q   <= '0;
         cnt_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_pkt_q   <= cdb_pkt_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cdb_valid    = cdb_valid_q;
   assign cdb_pkt      = cdb_pkt_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_cdb_arbiter;
   import cdb_types::*;

   localparam int unsigned N = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [N-1:0]         fu_valid;
   logic [N-1:0]         fu_ready;
   cdb_pkt_t [N-1:0]     fu_pkt;
   logic                 cdb_valid;
   cdb_pkt_t             cdb_pkt;
   logic [31:0]          conflict_cnt;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .fu_valid     (fu_valid),
      .fu_ready     (fu_ready),
      .fu_pkt       (fu_pkt),
      .cdb_valid    (cdb_valid),
      .cdb_pkt      (cdb_pkt),
      .conflict_cnt (conflict_cnt)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Winner is the valid lane at the smallest forward distance from the pointer.
   function automatic int pick(input logic [N-1:0] v, input int p);
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            d = (i - p + N) % N;
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      return best;
   endfunction

   function automatic cdb_pkt_t mk(input int rob, input logic [31:0] d);
      cdb_pkt_t p;
      p.rob_id  = ROB_IDX_W'(rob);
      p.pd      = PRF_IDX_W'(rob + 3);
      p.rd      = ARF_IDX_W'(rob + 1);
      p.data    = d;
      p.regf_we = 1'b1;
      return p;
   endfunction

   // Behavioural model state
   int       m_ptr       = 0;
   logic     m_cdb_valid = 1'b0;
   cdb_pkt_t m_cdb_pkt   = '0;
   longint   m_cnt       = 0;
   logic [N-1:0] m_xfer  = '0;

   always @(posedge clk) begin
      int g;
      g      = (rst || flush) ? -1 : pick(fu_valid, m_ptr);
      m_xfer = '0;
      if (rst) begin
         m_ptr       = 0;
         m_cdb_valid = 1'b0;
         m_cdb_pkt   = '0;
         m_cnt       = 0;
      end else begin
         if ($countones(fu_valid) > 1 && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (g >= 0) begin
            m_xfer[g]   = 1'b1;
            m_cdb_valid = 1'b1;
            m_cdb_pkt   = fu_pkt[g];
            m_ptr       = (g + 1) % N;
         end else begin
            m_cdb_valid = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int g;
      if (chk_en) begin
         g       = (rst || flush) ? -1 : pick(fu_valid, m_ptr);
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("model_fu_ready", 64'(fu_ready), 64'(exp_rdy));
         check("model_cdb_valid", 64'(cdb_valid), 64'(m_cdb_valid));
         check("model_conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
         if (m_cdb_valid) check("model_cdb_pkt", 64'(cdb_pkt), 64'(m_cdb_pkt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waited;
      logic found;
      cdb_pkt_t p;

      rst      = 1'b1;
      flush    = 1'b0;
      fu_valid = '0;
      fu_pkt   = '0;
      tick();
      fu_valid = '1;
      @(negedge clk);
      check("rst_fu_ready", 64'(fu_ready), 64'h0);
      check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
      check("rst_cdb_pkt", 64'(cdb_pkt), 64'h0);
      check("rst_conflict_cnt", 64'(conflict_cnt), 64'h0);
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // All four lanes held valid for eight cycles from ptr=0
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) fu_pkt[i] = mk(k, 32'(i * 256 + k));
         @(negedge clk);
         check("all4_ready", 64'(fu_ready), 64'(4'b0001 << (k % 4)));
         if (k > 0) begin
            check("all4_cdb_valid", 64'(cdb_valid), 64'h1);
            check("all4_cdb_data", 64'(cdb_pkt.data), 64'(((k - 1) % 4) * 256 + (k - 1)));
         end
         tick();
      end
      fu_valid = '0;
      @(negedge clk);
      check("all4_last_data", 64'(cdb_pkt.data), 64'(3 * 256 + 7));
      check("all4_conflict_cnt", 64'(conflict_cnt), 64'd8);
      tick();

      // Lane 2 alone
      fu_valid  = 4'b0100;
      fu_pkt[2] = mk(7, 32'hDEAD_BEEF);
      @(negedge clk);
      check("lane2_ready", 64'(fu_ready), 64'b0100);
      tick();
      fu_valid = '0;
      @(negedge clk);
      check("lane2_cdb_valid", 64'(cdb_valid), 64'h1);
      check("lane2_cdb_rob", 64'(cdb_pkt.rob_id), 64'd7);
      check("lane2_cdb_data", 64'(cdb_pkt.data), 64'hDEAD_BEEF);
      tick();

      // ptr=3 with lanes 0 and 3: wrap 3 -> 0 -> 1
      fu_valid  = 4'b1001;
      fu_pkt[0] = mk(10, 32'h0000_0A0A);
      fu_pkt[3] = mk(13, 32'h0000_0D0D);
      @(negedge clk);
      check("wrap_ready3", 64'(fu_ready), 64'b1000);
      tick();
      fu_valid = 4'b0001;
      @(negedge clk);
      check("wrap_ready0", 64'(fu_ready), 64'b0001);
      check("wrap_cdb_rob13", 64'(cdb_pkt.rob_id), 64'd13);
      tick();
      fu_valid = '0;
      @(negedge clk);
      check("wrap_cdb_rob10", 64'(cdb_pkt.rob_id), 64'd10);
      tick();

      // Flush with lanes 1 and 2 valid
      fu_valid  = 4'b0110;
      fu_pkt[1] = mk(21, 32'h2121_2121);
      fu_pkt[2] = mk(22, 32'h2222_2222);
      flush     = 1'b1;
      @(negedge clk);
      check("flush_ready", 64'(fu_ready), 64'h0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("flush_cdb_valid", 64'(cdb_valid), 64'h0);
      check("postflush_ready", 64'(fu_ready), 64'b0010);
      tick();
      fu_valid = 4'b0100;
      @(negedge clk);
      check("postflush_cdb_rob", 64'(cdb_pkt.rob_id), 64'd21);
      tick();
      fu_valid = '0;
      tick();

      // Reset while a packet is on the bus; held payload granted once afterwards
      fu_valid  = 4'b0001;
      fu_pkt[0] = mk(30, 32'h3030_3030);
      tick();
      fu_valid  = 4'b1000;
      fu_pkt[3] = mk(31, 32'h3131_3131);
      rst       = 1'b1;
      @(negedge clk);
      check("rstmid_cdb_valid_before", 64'(cdb_valid), 64'h1);
      check("rstmid_ready", 64'(fu_ready), 64'h0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_cdb_valid_after", 64'(cdb_valid), 64'h0);
      check("rstmid_conflict_cnt", 64'(conflict_cnt), 64'h0);
      check("rstmid_regrant", 64'(fu_ready), 64'b1000);
      tick();
      fu_valid = '0;
      @(negedge clk);
      check("rstmid_cdb_rob31", 64'(cdb_pkt.rob_id), 64'd31);
      tick();

      // Lane 1 held while lane 0 keeps requesting
      fu_valid  = 4'b0011;
      fu_pkt[1] = mk(17, 32'h1234_5678);
      fu_pkt[0] = mk(1, 32'h0);
      waited    = 0;
      found     = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (fu_ready[1]) begin
            found = 1'b1;
         end else begin
            tick();
            fu_pkt[0] = mk(k + 2, 32'(k));
            waited++;
         end
      end
      check("starve_found", 64'(found), 64'h1);
      check("starve_wait", 64'(waited), 64'd1);
      tick();
      fu_valid = 4'b0001;
      @(negedge clk);
      check("starve_cdb_rob", 64'(cdb_pkt.rob_id), 64'd17);
      check("starve_cdb_data", 64'(cdb_pkt.data), 64'h1234_5678);
      tick();
      fu_valid = '0;

      // Random traffic obeying the valid/hold handshake
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst   = ($urandom_range(99) < 1);
         flush = ($urandom_range(99) < 6);
         for (int i = 0; i < N; i++) begin
            if (fu_valid[i] && m_xfer[i]) fu_valid[i] = 1'b0;
            if (!fu_valid[i] && $urandom_range(99) < 45) begin
               p.rob_id  = ROB_IDX_W'($urandom);
               p.pd      = PRF_IDX_W'($urandom);
               p.rd      = ARF_IDX_W'($urandom);
               p.data    = $urandom;
               p.regf_we = 1'($urandom);
               fu_pkt[i] = p;
               fu_valid[i] = 1'b1;
            end
         end
      end
      tick();
      rst      = 1'b0;
      flush    = 1'b0;
      fu_valid = '0;
      tick();
      tick();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
